// File: rtl/ref_seq_reader_pkg.sv
// Shared constants and FSM encoding for the
// Smith-Waterman reference read path.
package ref_seq_reader_pkg;

  localparam int ADDR_W = 25;
  localparam int DEF_REF_LENGTH = 128;
  localparam int DEF_DRAM_WIDTH = 128;

  typedef enum logic [1:0] {
    REF_IDLE  = 2'd0,
    REF_FETCH = 2'd1,
    REF_DRAIN = 2'd2
  } ref_state_e;

endpackage

// File: rtl/ref_seq_reader_if.sv
// Descriptor, block and DRAM read signals of
// the reference sequence reader.
interface ref_seq_reader_if
  import ref_seq_reader_pkg::*;
#(
  parameter int REF_LENGTH = DEF_REF_LENGTH,
  parameter int DRAM_WIDTH = DEF_DRAM_WIDTH
);

  logic [ADDR_W-1:0] ref_addr_in;
  logic [ADDR_W-1:0] ref_length_in;
  logic ref_info_valid_in;
  logic [2*REF_LENGTH-1:0] ref_seq_block_out;
  logic ref_seq_block_valid_out;
  logic ref_seq_block_rdy_in;
  logic [ADDR_W-1:0] dram_rd_addr_out;
  logic dram_rd_en_out;
  logic dram_rd_rdy_in;
  logic [DRAM_WIDTH-1:0] dram_rd_data_in;
  logic dram_rd_data_valid_in;
  logic busy_out;
  logic info_dropped_out;

  modport slave (
    input  ref_addr_in,
    input  ref_length_in,
    input  ref_info_valid_in,
    output ref_seq_block_out,
    output ref_seq_block_valid_out,
    input  ref_seq_block_rdy_in,
    output dram_rd_addr_out,
    output dram_rd_en_out,
    input  dram_rd_rdy_in,
    input  dram_rd_data_in,
    input  dram_rd_data_valid_in,
    output busy_out,
    output info_dropped_out
  );

  modport master (
    output ref_addr_in,
    output ref_length_in,
    output ref_info_valid_in,
    input  ref_seq_block_out,
    input  ref_seq_block_valid_out,
    output ref_seq_block_rdy_in,
    input  dram_rd_addr_out,
    input  dram_rd_en_out,
    output dram_rd_rdy_in,
    output dram_rd_data_in,
    output dram_rd_data_valid_in,
    input  busy_out,
    input  info_dropped_out
  );

endinterface

// File: rtl/ref_seq_reader_block_fifo.sv
// Single-clock first-word fall-through block FIFO
// with occupancy; head entry is read straight from flops.
module ref_seq_reader_block_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [WIDTH-1:0] din,
  input  logic pop,
  output logic [WIDTH-1:0] dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic do_pop;
  logic do_push;

  assign do_pop = pop & (count != '0);
  assign do_push = push & ((count != FULL) | do_pop);
  assign dout = mem[rp];

  // storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (PW+1)'(do_push)
                     - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ref_seq_reader.sv
// Reference sequence reader: issues DRAM word reads under
// credit control and packs returned words into blocks.
module ref_seq_reader
  import ref_seq_reader_pkg::*;
#(
  parameter int REF_LENGTH = DEF_REF_LENGTH,
  parameter int DRAM_WIDTH = DEF_DRAM_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  ref_seq_reader_if.slave bus
);

  localparam int BW = 2 * REF_LENGTH;
  localparam int WPB = BW / DRAM_WIDTH;
  localparam int WB = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int RW = ADDR_W + $clog2(WPB);
  localparam int CMAX = FIFO_DEPTH * WPB;
  localparam int CW = $clog2(CMAX + 1);
  localparam int OW = $clog2(FIFO_DEPTH) + 1;

  ref_state_e state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] dlv;
  logic [RW-1:0] req;
  logic [RW-1:0] total;
  logic [CW-1:0] credits;
  logic [BW-1:0] pack;
  logic [WB-1:0] widx;
  logic en_q;
  logic [ADDR_W-1:0] addr_q;
  logic drop_q;

  logic [BW-1:0] fifo_dout;
  logic [OW-1:0] occ;
  logic [BW-1:0] block_nx;
  logic [RW-1:0] req_nx;
  logic [CW-1:0] cred_nx;
  logic fifo_valid;
  logic fire;
  logic pop;
  logic resp;
  logic push;
  logic last_dlv;

  assign fifo_valid = (occ != '0);
  assign fire = en_q & bus.dram_rd_rdy_in;
  assign pop = fifo_valid & bus.ref_seq_block_rdy_in;
  assign resp = bus.dram_rd_data_valid_in
              & (state != REF_IDLE);
  assign push = resp & (widx == WB'(WPB - 1));
  assign req_nx = req + RW'(fire);
  assign cred_nx = credits - CW'(fire)
                 + (pop ? CW'(WPB) : CW'(0));
  assign last_dlv = pop & (dlv + ADDR_W'(1) == len);

  // insert the returned word into its slot
  always_comb begin
    block_nx = pack;
    block_nx[int'(widx)*DRAM_WIDTH +: DRAM_WIDTH] =
      bus.dram_rd_data_in;
  end

  ref_seq_reader_block_fifo #(
    .WIDTH(BW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(block_nx),
    .pop(pop),
    .dout(fifo_dout),
    .count(occ)
  );

  // credits: free word slots not yet promised to a read
  always_ff @(posedge clk) begin
    if (rst) credits <= CW'(CMAX);
    else credits <= cred_nx;
  end

  // word packer
  always_ff @(posedge clk) begin
    if (rst) begin
      pack <= '0;
      widx <= '0;
    end else if (resp) begin
      pack <= block_nx;
      widx <= push ? '0 : widx + 1'b1;
    end
  end

  // descriptor FSM with registered request outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REF_IDLE;
      base <= '0;
      len <= '0;
      dlv <= '0;
      req <= '0;
      total <= '0;
      en_q <= 1'b0;
      addr_q <= '0;
      drop_q <= 1'b0;
    end else begin
      if (pop) dlv <= dlv + ADDR_W'(1);
      unique case (state)
        REF_IDLE: begin
          if (bus.ref_info_valid_in) begin
            base <= bus.ref_addr_in;
            len <= bus.ref_length_in;
            total <= RW'(bus.ref_length_in) * RW'(WPB);
            req <= '0;
            dlv <= '0;
            if (bus.ref_length_in != '0) begin
              state <= REF_FETCH;
              en_q <= (cred_nx != '0);
              addr_q <= bus.ref_addr_in;
            end
          end
        end
        REF_FETCH: begin
          if (bus.ref_info_valid_in) drop_q <= 1'b1;
          req <= req_nx;
          addr_q <= base + ADDR_W'(req_nx);
          if (req_nx == total) begin
            state <= REF_DRAIN;
            en_q <= 1'b0;
          end else begin
            en_q <= (cred_nx != '0);
          end
        end
        REF_DRAIN: begin
          if (bus.ref_info_valid_in) drop_q <= 1'b1;
          if (last_dlv) state <= REF_IDLE;
        end
        default: state <= REF_IDLE;
      endcase
    end
  end

  assign bus.ref_seq_block_out = fifo_dout;
  assign bus.ref_seq_block_valid_out = fifo_valid;
  assign bus.dram_rd_addr_out = addr_q;
  assign bus.dram_rd_en_out = en_q;
  assign bus.busy_out = (state != REF_IDLE);
  assign bus.info_dropped_out = drop_q;

endmodule

// File: tb/tb_ref_seq_reader.sv
// Scoreboard bench for ref_seq_reader: DRAM model, random
// handshakes, expected blocks derived from descriptors.
module tb_ref_seq_reader;

  localparam int LIM = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;

  ref_seq_reader_if #(
    .REF_LENGTH(128),
    .DRAM_WIDTH(128)
  ) bus ();

  ref_seq_reader #(
    .REF_LENGTH(128),
    .DRAM_WIDTH(128),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [24:0] a;
    int due;
  } pend_t;

  logic [255:0] exp_blk [$];
  logic [24:0] exp_addr [$];
  pend_t pend [$];

  // knobs written only by the stimulus process
  int dram_mode = 1;
  int blk_mode = 1;
  int lat_lo = 5;
  int lat_hi = 5;

  // counters written only by the monitor process
  int req_seen = 0;
  int blk_seen = 0;
  int last_pop_cyc = 0;

  function automatic logic [127:0] dword(input logic [24:0] a);
    logic [31:0] x;
    x = {7'd0, a};
    return {x ^ 32'hDEADBEEF, x * 32'h9E3779B1, ~x, x};
  endfunction

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom_range(1, 0));
  endfunction

  // DRAM model and output monitor
  initial begin : monitor
    logic rr;
    logic br;
    logic hold;
    logic [255:0] hold_blk;
    int last_due;
    int due;
    pend_t p;
    hold = 1'b0;
    hold_blk = '0;
    last_due = 0;
    bus.dram_rd_rdy_in = 1'b0;
    bus.dram_rd_data_valid_in = 1'b0;
    bus.dram_rd_data_in = '0;
    bus.ref_seq_block_rdy_in = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete();
        last_due = 0;
        hold = 1'b0;
        bus.dram_rd_data_valid_in = 1'b0;
        bus.dram_rd_rdy_in = 1'b0;
        bus.ref_seq_block_rdy_in = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid",
              bus.ref_seq_block_valid_out, 1'b1);
          chk("hold_data", bus.ref_seq_block_out, hold_blk);
        end
        bus.dram_rd_data_valid_in = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          p = pend.pop_front();
          bus.dram_rd_data_valid_in = 1'b1;
          bus.dram_rd_data_in = dword(p.a);
        end
        rr = pick(dram_mode);
        bus.dram_rd_rdy_in = rr;
        if (bus.dram_rd_en_out && rr) begin
          req_seen++;
          if (exp_addr.size() == 0) begin
            chk("rd_extra", 0, 1);
          end else begin
            chk("rd_addr", bus.dram_rd_addr_out,
                exp_addr.pop_front());
          end
          due = cyc + $urandom_range(lat_hi, lat_lo);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back('{bus.dram_rd_addr_out, due});
        end
        br = pick(blk_mode);
        bus.ref_seq_block_rdy_in = br;
        hold = bus.ref_seq_block_valid_out && !br;
        hold_blk = bus.ref_seq_block_out;
        if (bus.ref_seq_block_valid_out && br) begin
          blk_seen++;
          last_pop_cyc = cyc;
          if (exp_blk.size() == 0) begin
            chk("blk_extra", 0, 1);
          end else begin
            chk("blk_data", bus.ref_seq_block_out,
                exp_blk.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_cyc();
    @(negedge clk);
    #1;
  endtask

  // reference model: expected reads and blocks
  task automatic issue(input logic [24:0] a,
                       input logic [24:0] n);
    bus.ref_addr_in = a;
    bus.ref_length_in = n;
    bus.ref_info_valid_in = 1'b1;
    for (int k = 0; k < int'(n); k++) begin
      exp_blk.push_back({dword(a + 25'(2*k + 1)),
                         dword(a + 25'(2*k))});
      exp_addr.push_back(a + 25'(2*k));
      exp_addr.push_back(a + 25'(2*k + 1));
    end
    wait_cyc();
    bus.ref_info_valid_in = 1'b0;
    chk("busy_t1", bus.busy_out, n != 0);
    chk("rd_en_t1", bus.dram_rd_en_out, n != 0);
    if (n != 0) chk("rd_addr_t1", bus.dram_rd_addr_out, a);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((bus.busy_out || exp_blk.size() != 0)
           && n < LIM) begin
      wait_cyc();
      n++;
    end
    chk({nm, "_in_time"}, n < LIM, 1'b1);
    chk({nm, "_reads_done"}, exp_addr.size(), 0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_valid"}, bus.ref_seq_block_valid_out, 1'b0);
    chk({nm, "_block"}, bus.ref_seq_block_out, 0);
    chk({nm, "_rd_en"}, bus.dram_rd_en_out, 1'b0);
    chk({nm, "_rd_addr"}, bus.dram_rd_addr_out, 0);
    chk({nm, "_busy"}, bus.busy_out, 1'b0);
    chk({nm, "_dropped"}, bus.info_dropped_out, 1'b0);
  endtask

  initial begin : stimulus
    int r0;
    int b0;
    int n;
    logic [24:0] a;
    bus.ref_addr_in = '0;
    bus.ref_length_in = '0;
    bus.ref_info_valid_in = 1'b0;
    rst = 1'b1;
    repeat (3) wait_cyc();
    chk_reset("por");
    rst = 1'b0;
    wait_cyc();

    // basic read with fixed latency
    r0 = req_seen;
    b0 = blk_seen;
    issue(25'h100, 25'd3);
    wait_done("basic");
    chk("basic_busy_fall", cyc, last_pop_cyc + 1);
    chk("basic_reads", req_seen - r0, 6);
    chk("basic_blocks", blk_seen - b0, 3);

    // zero length descriptor
    r0 = req_seen;
    issue(25'h200, 25'd0);
    repeat (4) begin
      chk("zero_busy", bus.busy_out, 1'b0);
      chk("zero_rd_en", bus.dram_rd_en_out, 1'b0);
      wait_cyc();
    end
    chk("zero_reads", req_seen - r0, 0);
    chk("zero_no_block", bus.ref_seq_block_valid_out, 1'b0);

    // block backpressure limits reads to the credit pool
    lat_lo = 1;
    lat_hi = 6;
    blk_mode = 0;
    r0 = req_seen;
    b0 = blk_seen;
    issue(25'h3000, 25'd10);
    repeat (40) wait_cyc();
    chk("bp_reads", req_seen - r0, 8);
    chk("bp_rd_en", bus.dram_rd_en_out, 1'b0);
    chk("bp_valid", bus.ref_seq_block_valid_out, 1'b1);
    blk_mode = 2;
    wait_done("bp");
    chk("bp_blocks", blk_seen - b0, 10);
    chk("bp_reads_all", req_seen - r0, 20);

    // random DRAM stalls and random descriptors
    dram_mode = 2;
    for (int i = 0; i < 5; i++) begin
      a = (i == 0) ? 25'h1FFFFFD : 25'($urandom);
      b0 = blk_seen;
      n = $urandom_range(6, 1);
      issue(a, 25'(n));
      wait_done("rand");
      chk("rand_blocks", blk_seen - b0, n);
    end

    // dropped descriptor while busy
    b0 = blk_seen;
    issue(25'h2000, 25'd4);
    repeat (3) wait_cyc();
    bus.ref_addr_in = 25'h9999;
    bus.ref_length_in = 25'd5;
    bus.ref_info_valid_in = 1'b1;
    wait_cyc();
    bus.ref_info_valid_in = 1'b0;
    chk("drop_flag", bus.info_dropped_out, 1'b1);
    wait_done("drop");
    chk("drop_blocks", blk_seen - b0, 4);
    chk("drop_sticky", bus.info_dropped_out, 1'b1);

    // reset in the middle of a descriptor
    dram_mode = 1;
    blk_mode = 1;
    b0 = blk_seen;
    issue(25'h5000, 25'd8);
    n = 0;
    while (blk_seen - b0 < 2 && n < LIM) begin
      wait_cyc();
      n++;
    end
    chk("mid_reach_blk2", n < LIM, 1'b1);
    dram_mode = 0;
    blk_mode = 0;
    repeat (2) wait_cyc();
    rst = 1'b1;
    exp_blk.delete();
    exp_addr.delete();
    wait_cyc();
    chk_reset("mid");
    rst = 1'b0;
    wait_cyc();
    dram_mode = 1;
    blk_mode = 1;
    b0 = blk_seen;
    issue(25'h40, 25'd1);
    wait_done("post");
    chk("post_blocks", blk_seen - b0, 1);
    chk("post_dropped", bus.info_dropped_out, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
